// File: rtl/icache_nway_pkg.sv
// Shared definitions for the N-way instruction cache.
//   icacheState_e : refill controller states (idle lookup, word refill, tag commit)
//   clog2Safe     : $clog2 that never returns 0, so single-entry fields still get one bit
package icache_nway_pkg;

  typedef enum logic [1:0] {
    ICacheIdle   = 2'd0,
    ICacheRefill = 2'd1,
    ICacheCommit = 2'd2
  } icacheState_e;

  function automatic int clog2Safe(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: tag, valid and data arrays for every set.
// Ports:
//   clk, rst                 clock, synchronous active-low reset (valid bits only)
//   rdIdx_i, rdWord_i        combinational read address (set index, word in line)
//   rdTag_o, rdValid_o       tag and valid bit of the addressed set
//   rdData_o                 addressed data word
//   dataWe_i, wrWord_i,
//   wrData_i                 refill data word write into set wrIdx_i
//   tagWe_i, wrTag_i,
//   wrValid_i                tag + valid write into set wrIdx_i
//   wrIdx_i                  set index shared by both write ports
//   clrAll_i                 clear every valid bit; wins over a tag/valid write
module icache_way
  import icache_nway_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [clog2Safe(SETS)-1:0]       rdIdx_i,
  input  logic [clog2Safe(LINE_WORDS)-1:0] rdWord_i,
  output logic [TAG_W-1:0]              rdTag_o,
  output logic                          rdValid_o,
  output logic [31:0]                   rdData_o,
  input  logic [clog2Safe(SETS)-1:0]       wrIdx_i,
  input  logic                          dataWe_i,
  input  logic [clog2Safe(LINE_WORDS)-1:0] wrWord_i,
  input  logic [31:0]                   wrData_i,
  input  logic                          tagWe_i,
  input  logic [TAG_W-1:0]              wrTag_i,
  input  logic                          wrValid_i,
  input  logic                          clrAll_i
);

  localparam int IDX_W = clog2Safe(SETS);
  localparam int OFF_W = clog2Safe(LINE_WORDS);

  logic [TAG_W-1:0] tagArr_q  [SETS];
  logic [31:0]      dataArr_q [SETS*LINE_WORDS];
  logic [SETS-1:0]  valid_q;

  assign rdTag_o   = tagArr_q[rdIdx_i];
  assign rdValid_o = valid_q[rdIdx_i];
  assign rdData_o  = dataArr_q[{rdIdx_i, rdWord_i}];

  // Valid bits are the only reset state; a bulk clear beats a single-set write
  // so an invalidate landing on a commit leaves that line invalid too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clrAll_i) begin
      valid_q <= '0;
    end else if (tagWe_i) begin
      valid_q[wrIdx_i] <= wrValid_i;
    end
  end

  // Tag and data storage carry no reset; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (tagWe_i) begin
      tagArr_q[wrIdx_i] <= wrTag_i;
    end
    if (dataWe_i) begin
      dataArr_q[{wrIdx_i, wrWord_i}] <= wrData_i;
    end
  end

  logic [IDX_W+OFF_W-1:0] unusedWidthCheck;
  assign unusedWidthCheck = {wrIdx_i, wrWord_i};

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with word-serial line refill.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ce_i, pc_i               fetch enable and word-aligned fetch address
//   inst_o                   instruction, valid when ce_i && !stallreq_o
//   stallreq_o               miss or refill in progress
//   inval_i                  one-cycle pulse invalidating the whole cache
//   mem_req_o, mem_addr_o    refill word request and its byte address
//   mem_ready_i, mem_data_i  refill word handshake and data
module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [31:0]       inst_o,
  output logic              stallreq_o,
  input  logic              inval_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_data_i
);

  localparam int OFF_W = clog2Safe(LINE_WORDS);
  localparam int IDX_W = clog2Safe(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int WAY_W = clog2Safe(WAYS);

  icacheState_e      state_q, state_d;
  logic [ADDR_W-1:0] lineBase_q, lineBase_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              invalPend_q, invalPend_d;
  logic [WAY_W-1:0]  rr_q [SETS];

  logic [IDX_W-1:0] pcIdx, baseIdx, wrIdx;
  logic [TAG_W-1:0] pcTag, baseTag, wrTag;
  logic [OFF_W-1:0] pcWord;

  logic [TAG_W-1:0] wayTag  [WAYS];
  logic [31:0]      wayData [WAYS];
  logic [WAYS-1:0]  wayValid, dataWe, tagWe;
  logic             tagValid, clrAll, rrBump, hitAny;
  logic [31:0]      hitData;
  logic [WAY_W-1:0] victimPick;

  assign pcWord  = pc_i[2 +: OFF_W];
  assign pcIdx   = pc_i[2+OFF_W +: IDX_W];
  assign pcTag   = pc_i[ADDR_W-1 -: TAG_W];
  assign baseIdx = lineBase_q[2+OFF_W +: IDX_W];
  assign baseTag = lineBase_q[ADDR_W-1 -: TAG_W];

  logic [1:0] unusedByteOffset;
  assign unusedByteOffset = pc_i[1:0];

  for (genvar g = 0; g < WAYS; g++) begin : gWay
    icache_way #(
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
    ) uWay (
      .clk      (clk),
      .rst      (rst),
      .rdIdx_i  (pcIdx),
      .rdWord_i (pcWord),
      .rdTag_o  (wayTag[g]),
      .rdValid_o(wayValid[g]),
      .rdData_o (wayData[g]),
      .wrIdx_i  (wrIdx),
      .dataWe_i (dataWe[g]),
      .wrWord_i (beat_q),
      .wrData_i (mem_data_i),
      .tagWe_i  (tagWe[g]),
      .wrTag_i  (wrTag),
      .wrValid_i(tagValid),
      .clrAll_i (clrAll)
    );
  end

  // Hit detection and victim choice; lowest-numbered way wins both searches.
  always_comb begin
    hitAny     = 1'b0;
    hitData    = '0;
    victimPick = rr_q[pcIdx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (wayValid[w] && (wayTag[w] == pcTag)) begin
        hitAny  = 1'b1;
        hitData = wayData[w];
      end
      if (!wayValid[w]) begin
        victimPick = WAY_W'(w);
      end
    end
  end

  // Refill controller; every output is held at zero while reset is asserted.
  always_comb begin
    state_d     = state_q;
    lineBase_d  = lineBase_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    invalPend_d = invalPend_q;
    inst_o      = '0;
    stallreq_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    dataWe      = '0;
    tagWe       = '0;
    tagValid    = 1'b0;
    clrAll      = 1'b0;
    rrBump      = 1'b0;
    wrIdx       = pcIdx;
    wrTag       = pcTag;
    if (rst) begin
      unique case (state_q)
        ICacheIdle: begin
          invalPend_d = 1'b0;
          clrAll      = inval_i;
          if (ce_i) begin
            if (hitAny) begin
              inst_o = hitData;
            end else begin
              // Drop the victim's valid now so a half-written line never hits.
              stallreq_o        = 1'b1;
              lineBase_d        = {pc_i[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
              victim_d          = victimPick;
              beat_d            = '0;
              tagWe[victimPick] = 1'b1;
              state_d           = ICacheRefill;
            end
          end
        end
        ICacheRefill: begin
          stallreq_o = 1'b1;
          mem_req_o  = 1'b1;
          mem_addr_o = lineBase_q + ADDR_W'({beat_q, 2'b00});
          wrIdx      = baseIdx;
          if (inval_i) begin
            invalPend_d = 1'b1;
          end
          if (mem_ready_i) begin
            dataWe[victim_q] = 1'b1;
            beat_d           = beat_q + OFF_W'(1);
            if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
              state_d = ICacheCommit;
            end
          end
        end
        ICacheCommit: begin
          // A pending invalidate clears everything, including the new line.
          stallreq_o      = 1'b1;
          wrIdx           = baseIdx;
          wrTag           = baseTag;
          tagWe[victim_q] = 1'b1;
          tagValid        = 1'b1;
          rrBump          = 1'b1;
          clrAll          = invalPend_q || inval_i;
          invalPend_d     = 1'b0;
          state_d         = ICacheIdle;
        end
        default: state_d = ICacheIdle;
      endcase
    end
  end

  // Controller state and per-set round-robin pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ICacheIdle;
      lineBase_q  <= '0;
      victim_q    <= '0;
      beat_q      <= '0;
      invalPend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lineBase_q  <= lineBase_d;
      victim_q    <= victim_d;
      beat_q      <= beat_d;
      invalPend_q <= invalPend_d;
      if (rrBump) begin
        rr_q[baseIdx] <= (WAYS == 1) ? '0 : rr_q[baseIdx] + WAY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway (WAYS=2, SETS=64, LINE_WORDS=4).
// External memory returns {16'hC0DE, addr[15:0]} when ready and a poison word
// otherwise, so any write taken on a not-ready cycle shows up as bad data.
module tb_icache_nway;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        inval_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;

  int assertCount = 0;
  int failCount   = 0;

  icache_nway #(
    .WAYS(2), .SETS(64), .LINE_WORDS(4), .ADDR_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .pc_i       (pc_i),
    .inst_o     (inst_o),
    .stallreq_o (stallreq_o),
    .inval_i    (inval_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ready_i(mem_ready_i),
    .mem_data_i (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  assign mem_data_i = mem_ready_i ? memWord(mem_addr_o) : 32'hBAD0_BAD0;

  // Drive inputs just after a rising edge, then settle to the falling edge.
  task automatic applyStimulus(input logic ce, input logic [31:0] pc,
                               input logic ready, input logic inval);
    ce_i        = ce;
    pc_i        = pc;
    mem_ready_i = ready;
    inval_i     = inval;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Full miss sequence: miss cycle, four beats (with optional wait states and
  // an optional invalidate pulse on one beat, pc optionally redirected), commit.
  task automatic runMiss(input logic [31:0] pc, input int waits,
                         input int invalBeat, input logic [31:0] flushPc);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    applyStimulus(1'b1, pc, 1'b0, 1'b0);
    checkOutput("missStall", {31'd0, stallreq_o}, 32'd1);
    checkOutput("missNoReq", {31'd0, mem_req_o}, 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < waits; w++) begin
        applyStimulus(1'b1, flushPc, 1'b0, 1'b0);
        checkOutput("waitAddr", mem_addr_o, base + 32'(4 * b));
        checkOutput("waitStall", {31'd0, stallreq_o}, 32'd1);
        tick();
      end
      applyStimulus(1'b1, flushPc, 1'b1, (b == invalBeat));
      checkOutput("beatReq", {31'd0, mem_req_o}, 32'd1);
      checkOutput("beatAddr", mem_addr_o, base + 32'(4 * b));
      checkOutput("beatStall", {31'd0, stallreq_o}, 32'd1);
      tick();
    end
    applyStimulus(1'b1, flushPc, 1'b0, 1'b0);
    checkOutput("commitStall", {31'd0, stallreq_o}, 32'd1);
    checkOutput("commitNoReq", {31'd0, mem_req_o}, 32'd0);
    tick();
  endtask

  task automatic expectHit(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b0, 1'b0);
    checkOutput("hitStall", {31'd0, stallreq_o}, 32'd0);
    checkOutput("hitInst", inst_o, memWord(pc));
    checkOutput("hitNoReq", {31'd0, mem_req_o}, 32'd0);
    tick();
  endtask

  initial begin
    rst         = 1'b0;
    ce_i        = 1'b1;
    pc_i        = 32'h100;
    inval_i     = 1'b0;
    mem_ready_i = 1'b0;
    tick();
    tick();

    // Reset: all outputs quiet even with a fetch requested.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    checkOutput("rstStall", {31'd0, stallreq_o}, 32'd0);
    checkOutput("rstReq", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rstAddr", mem_addr_o, 32'd0);
    checkOutput("rstInst", inst_o, 32'd0);
    tick();
    rst = 1'b1;

    // Fetch disabled: no lookup, no transition.
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0);
    checkOutput("ceOffInst", inst_o, 32'd0);
    checkOutput("ceOffStall", {31'd0, stallreq_o}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0);
    checkOutput("ceOffReq", {31'd0, mem_req_o}, 32'd0);
    tick();

    // Cold miss then hits in the filled line.
    runMiss(32'h100, 0, -1, 32'h100);
    expectHit(32'h100);
    expectHit(32'h104);
    expectHit(32'h108);

    // Eviction in set 0: third line evicts way0, then round-robin moves on.
    runMiss(32'h000, 0, -1, 32'h000);
    runMiss(32'h400, 0, -1, 32'h400);
    runMiss(32'h800, 0, -1, 32'h800);
    expectHit(32'h404);
    expectHit(32'h80C);
    runMiss(32'h000, 0, -1, 32'h000);
    expectHit(32'h800);
    runMiss(32'h400, 0, -1, 32'h400);
    expectHit(32'h008);

    // Three wait states per beat.
    runMiss(32'h300, 3, -1, 32'h300);
    expectHit(32'h300);
    expectHit(32'h30C);

    // Invalidate in idle: same-cycle lookup still hits, next fetch misses.
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b1);
    checkOutput("invalSameStall", {31'd0, stallreq_o}, 32'd0);
    checkOutput("invalSameInst", inst_o, memWord(32'h104));
    tick();
    runMiss(32'h100, 0, -1, 32'h100);
    expectHit(32'h10C);

    // Invalidate during refill: line lands invalid and everything is cleared.
    runMiss(32'h200, 0, 1, 32'h200);
    runMiss(32'h200, 0, -1, 32'h200);
    expectHit(32'h204);
    runMiss(32'h100, 0, -1, 32'h100);
    expectHit(32'h100);

    // Branch flush during refill: original line completes, new pc then misses.
    runMiss(32'h500, 0, -1, 32'h604);
    runMiss(32'h604, 0, -1, 32'h604);
    expectHit(32'h50C);
    expectHit(32'h608);

    // Reset during beat 2 of a refill.
    runMiss(32'h700, 0, -1, 32'h700);
    applyStimulus(1'b1, 32'h710, 1'b0, 1'b0);
    checkOutput("rstMidMiss", {31'd0, stallreq_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h710, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h710, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h710, 1'b1, 1'b0);
    checkOutput("rstMidBeat2Addr", mem_addr_o, 32'h718);
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 32'h710, 1'b0, 1'b0);
    checkOutput("rstMidReq", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rstMidStall", {31'd0, stallreq_o}, 32'd0);
    tick();
    rst = 1'b1;
    runMiss(32'h100, 0, -1, 32'h100);
    expectHit(32'h104);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
